output_mem_if: RTL and testbench
================================

Name: output_mem_if

Overview:
- Write-side counterpart to the input/weight BRAM readers.
- Accepts a serial stream of signed accumulator results from the MAC array and requantizes each to DATA_W with arithmetic shift and saturation.
- Packs N_MACS results per line and writes completed lines to a Block Memory Generator port starting at a programmed base address.
- Signals completion after a programmed number of lines.

Parameters:
- N_MACS, 4, results packed per BRAM line (power of two, >=2)
- DATA_W, 16, stored result width
- ACC_W, 40, incoming accumulator width (ACC_W > DATA_W)
- SHIFT, 8, arithmetic right shift applied before saturation (0..ACC_W-DATA_W)
- MEM_DEPTH, 256, BRAM lines; AW = $clog2(MEM_DEPTH)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle pulse; latches base_addr/num_lines, begins layer
- base_addr  in  AW  first BRAM line to write
- num_lines  in  AW+1  lines to write this layer (0..MEM_DEPTH)
- res_valid  in  1  res_in valid
- res_in  in  ACC_W  signed accumulator result
- res_ready  out  1  block can accept res_in this cycle
- flush  in  1  write current partial line (zero padded)
- busy  out  1  layer in progress
- done  out  1  one-cycle pulse, last line written
- wr_count  out  AW+1  lines written since last start
- bram_addr  out  AW  BRAM write address
- bram_en  out  1  BRAM enable (equals bram_we)
- bram_we  out  1  BRAM write enable
- bram_din  out  N_MACS*DATA_W  line data; lane k at bits [DATA_W*k +: DATA_W]

Behaviour:
- Reset: all outputs 0. FSM in IDLE. Lane counter, line buffer, address and lines_left cleared. A reset mid-layer aborts it with no further writes.
- FSM states: IDLE, ACTIVE.
- IDLE:
  - res_ready=0, busy=0.
  - start with num_lines>0: wr_addr<=base_addr, lines_left<=num_lines, wr_count<=0, lane<=0, buffer cleared, go ACTIVE.
  - start with num_lines==0: done pulses next cycle, no write, stay IDLE.
- ACTIVE:
  - res_ready=1, busy=1. start is ignored.
- Accept (res_valid && res_ready):
  - q = res_in >>> SHIFT, computed as signed at full ACC_W width.
  - If q > 2^(DATA_W-1)-1, store 2^(DATA_W-1)-1. If q < -2^(DATA_W-1), store -2^(DATA_W-1). Otherwise store q[DATA_W-1:0].
  - The stored value goes into buffer lane `lane`, then lane++.
- Line complete (accept with lane==N_MACS-1), or flush with a non-empty line:
  - Next cycle: bram_we=bram_en=1, bram_addr=wr_addr, bram_din=line. For flush, unfilled lanes are 0.
  - Write latency: exactly 1 cycle after the accepting/flush edge. All BRAM outputs are registered.
  - Same edge updates: buffer cleared, lane<=0, wr_count++, lines_left--.
  - wr_addr <= (wr_addr==MEM_DEPTH-1) ? 0 : wr_addr+1.
  - bram_we is a single-cycle pulse per line. Back-to-back lines may produce consecutive write pulses.
- Flush with lane==0 and no accept that cycle: no write.
- Flush and accept in the same cycle: the sample is placed first, then the line is written (full or partial) as one write.
- Last line (lines_left==1 at the write edge):
  - done=1 in the same cycle as its bram_we. FSM returns to IDLE that cycle, so res_ready=0 from that cycle on.
  - Results presented after this are not accepted.
- wr_count holds its value in IDLE until the next start.
- Address wrap: a layer whose lines cross MEM_DEPTH-1 continues at line 0.
- bram_din holds its last value when bram_we=0. Its value is don't-care then.

Test Plan:
- Reset, start base=0x10 num_lines=2, stream 8 results 0x100,0x200,...,0x800 (SHIFT=8) on consecutive cycles.
  - Expect writes to 0x10 with din=0x0004_0003_0002_0001 and 0x11 with din=0x0008_0007_0006_0005, each 1 cycle after the 4th/8th accept.
  - Expect done with the second write, then res_ready=0.
- Saturation: res_in = +2^30, -2^30, 0xFF (→0), -1 (→-1=0xFFFF).
  - Expect lanes 0x7FFF, 0x8000, 0x0000, 0xFFFF.
- Wrap: base=MEM_DEPTH-1, num_lines=2, 8 results.
  - Expect writes at addr 255 then 0, wr_count=2, done.
- Flush: num_lines=3, 4 results, then 2 results + flush in the same cycle as the 2nd, then flush alone with empty line.
  - Expect lines written: full, then {0,0,r6,r5}. No third write from the empty flush. wr_count=2, busy=1.
- Idle/ignore cases:
  - res_valid in IDLE → no accept, no write.
  - start during ACTIVE ignored: base and count unchanged.
  - start num_lines=0 → done next cycle, no bram_we.
- Reset mid-layer after 2 accepts: all outputs 0, IDLE.
  - A new start then writes to the new base with lane 0 fresh (no stale data in bram_din).

Source files
------------

// File: rtl/output_mem_if.sv
`default_nettype none
// ============================================================================
// Module      : output_mem_if
// Description : Requantizes a serial accumulator stream, packs N_MACS results
//               per line and writes completed lines into a BRAM port.
// Revision    : 1.0 - initial release
// ============================================================================
module output_mem_if #(
    parameter  int N_MACS    = 4,
    parameter  int DATA_W    = 16,
    parameter  int ACC_W     = 40,
    parameter  int SHIFT     = 8,
    parameter  int MEM_DEPTH = 256,
    localparam int AW        = $clog2(MEM_DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [AW-1:0]            base_addr,
    input  logic [AW:0]              num_lines,
    input  logic                     res_valid,
    input  logic [ACC_W-1:0]         res_in,
    output logic                     res_ready,
    input  logic                     flush,
    output logic                     busy,
    output logic                     done,
    output logic [AW:0]              wr_count,
    output logic [AW-1:0]            bram_addr,
    output logic                     bram_en,
    output logic                     bram_we,
    output logic [N_MACS*DATA_W-1:0] bram_din
);

    localparam int LW = $clog2(N_MACS);

    localparam logic c_IDLE   = 1'b0;
    localparam logic c_ACTIVE = 1'b1;

    localparam logic [LW-1:0] c_LAST_LANE = LW'(N_MACS - 1);
    localparam logic [AW-1:0] c_LAST_ADDR = AW'(MEM_DEPTH - 1);

    localparam logic signed [ACC_W-1:0] c_MAX =
        {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] c_MIN =
        {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    logic                     r_state;
    logic [LW-1:0]            r_lane;
    logic [N_MACS*DATA_W-1:0] r_line;
    logic [AW-1:0]            r_wr_addr;
    logic [AW:0]              r_lines_left;

    logic signed [ACC_W-1:0]  w_q;
    logic [DATA_W-1:0]        w_sat;
    logic                     w_accept;
    logic                     w_write;
    logic [N_MACS*DATA_W-1:0] w_line_next;

    assign w_q = $signed(res_in) >>> SHIFT;

    always_comb begin
        w_sat = w_q[DATA_W-1:0];
        if (w_q > c_MAX) begin
            w_sat = c_MAX[DATA_W-1:0];
        end else if (w_q < c_MIN) begin
            w_sat = c_MIN[DATA_W-1:0];
        end
    end

    assign w_accept = res_valid && res_ready;

    // A flush in the same cycle as an accept folds the new sample into the line.
    assign w_write = (r_state == c_ACTIVE) &&
                     ((w_accept && (r_lane == c_LAST_LANE)) ||
                      (flush && ((r_lane != '0) || w_accept)));

    for (genvar k = 0; k < N_MACS; k++) begin : g_lane
        assign w_line_next[k*DATA_W +: DATA_W] =
            (w_accept && (r_lane == LW'(k))) ? w_sat : r_line[k*DATA_W +: DATA_W];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= c_IDLE;
            r_lane       <= '0;
            r_line       <= '0;
            r_wr_addr    <= '0;
            r_lines_left <= '0;
            res_ready    <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            wr_count     <= '0;
            bram_addr    <= '0;
            bram_en      <= 1'b0;
            bram_we      <= 1'b0;
            bram_din     <= '0;
        end else begin
            bram_en <= 1'b0;
            bram_we <= 1'b0;
            done    <= 1'b0;
            if (r_state == c_IDLE) begin
                if (start) begin
                    if (num_lines != '0) begin
                        r_state      <= c_ACTIVE;
                        r_wr_addr    <= base_addr;
                        r_lines_left <= num_lines;
                        wr_count     <= '0;
                        r_lane       <= '0;
                        r_line       <= '0;
                        res_ready    <= 1'b1;
                        busy         <= 1'b1;
                    end else begin
                        done <= 1'b1;
                    end
                end
            end else begin
                if (w_accept) begin
                    r_line <= w_line_next;
                    r_lane <= r_lane + 1'b1;
                end
                if (w_write) begin
                    bram_en      <= 1'b1;
                    bram_we      <= 1'b1;
                    bram_addr    <= r_wr_addr;
                    bram_din     <= w_line_next;
                    r_line       <= '0;
                    r_lane       <= '0;
                    wr_count     <= wr_count + 1'b1;
                    r_lines_left <= r_lines_left - 1'b1;
                    r_wr_addr    <= (r_wr_addr == c_LAST_ADDR) ? '0 : r_wr_addr + 1'b1;
                    if (r_lines_left == (AW+1)'(1)) begin
                        done      <= 1'b1;
                        r_state   <= c_IDLE;
                        res_ready <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_output_mem_if.sv
`default_nettype none
// ============================================================================
// Module      : tb_output_mem_if
// Description : Self-checking bench for output_mem_if (vector table, directed
//               corner cases and randomized layers against a line model).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_output_mem_if;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  base_addr;
    logic [8:0]  num_lines;
    logic        res_valid;
    logic [39:0] res_in;
    logic        flush;
    logic        res_ready;
    logic        busy;
    logic        done;
    logic [8:0]  wr_count;
    logic [7:0]  bram_addr;
    logic        bram_en;
    logic        bram_we;
    logic [63:0] bram_din;

    output_mem_if dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .num_lines (num_lines),
        .res_valid (res_valid),
        .res_in    (res_in),
        .res_ready (res_ready),
        .flush     (flush),
        .busy      (busy),
        .done      (done),
        .wr_count  (wr_count),
        .bram_addr (bram_addr),
        .bram_en   (bram_en),
        .bram_we   (bram_we),
        .bram_din  (bram_din)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [7:0]  addr;
        logic [63:0] din;
        logic        done;
    } wr_t;

    typedef struct {
        logic [39:0] res;
        logic [15:0] exp;
    } vec_t;

    wr_t  wq[$];
    wr_t  eq[$];
    vec_t tbl[8];

    // reference model state: one line under construction per layer
    logic        m_active = 1'b0;
    int          m_addr   = 0;
    int          m_left   = 0;
    int          m_wc     = 0;
    int          m_cnt    = 0;
    logic [63:0] m_line   = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bram_we === 1'b1 || bram_en === 1'b1) begin
            wr_t w;
            chk("en_eq_we", {63'd0, bram_en}, {63'd0, bram_we});
            w.addr = bram_addr;
            w.din  = bram_din;
            w.done = done;
            wq.push_back(w);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] sat(input logic [39:0] a);
        longint x;
        x = longint'($signed(a)) >>> 8;
        if (x > 32767)  return 16'h7FFF;
        if (x < -32768) return 16'h8000;
        return 16'(x);
    endfunction

    function automatic logic [39:0] rnd();
        logic [63:0] r;
        int sel;
        r   = {$urandom(), $urandom()};
        sel = $urandom_range(0, 2);
        if (sel == 0) return r[39:0];
        if (sel == 1) return {{16{r[23]}}, r[23:0]};
        return {{24{r[15]}}, r[15:0]};
    endfunction

    task automatic start_layer(input int b, input int n);
        start     = 1'b1;
        base_addr = 8'(b);
        num_lines = 9'(n);
        if (!m_active && n > 0) begin
            m_active = 1'b1;
            m_addr   = b;
            m_left   = n;
            m_wc     = 0;
            m_cnt    = 0;
            m_line   = '0;
        end
        tick;
        start = 1'b0;
    endtask

    task automatic drive(input logic v, input logic [39:0] d, input logic fl);
        wr_t e;
        chk("res_ready", {63'd0, res_ready}, {63'd0, m_active});
        res_valid = v;
        res_in    = d;
        flush     = fl;
        if (v && m_active) begin
            m_line[16*m_cnt +: 16] = sat(d);
            m_cnt++;
        end
        if (m_active && (m_cnt == 4 || (fl && m_cnt > 0))) begin
            m_left--;
            m_wc++;
            e.addr = 8'(m_addr);
            e.din  = m_line;
            e.done = (m_left == 0);
            eq.push_back(e);
            m_addr = (m_addr + 1) % 256;
            m_line = '0;
            m_cnt  = 0;
            if (m_left == 0) m_active = 1'b0;
        end
        tick;
        res_valid = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic compare_writes(input string name);
        repeat (2) tick;
        chk({name, " count"}, 64'(wq.size()), 64'(eq.size()));
        chk({name, " wr_count"}, {55'd0, wr_count}, 64'(m_wc));
        while (eq.size() > 0 && wq.size() > 0) begin
            wr_t a;
            wr_t e;
            a = wq.pop_front();
            e = eq.pop_front();
            chk({name, " addr"}, {56'd0, a.addr}, {56'd0, e.addr});
            chk({name, " din"}, a.din, e.din);
            chk({name, " done"}, {63'd0, a.done}, {63'd0, e.done});
        end
        wq.delete();
        eq.delete();
    endtask

    task automatic do_reset;
        rst = 1'b1;
        #1;
        chk("rst outputs", {res_ready, busy, done, bram_en, bram_we, wr_count, bram_addr},
            64'd0);
        chk("rst din", bram_din, 64'd0);
        m_active = 1'b0;
        m_cnt    = 0;
        m_line   = '0;
        m_wc     = 0;
        tick;
        rst = 1'b0;
        wq.delete();
        eq.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{40'h00_4000_0000, 16'h7FFF};
        tbl[1] = '{40'hFF_C000_0000, 16'h8000};
        tbl[2] = '{40'h00_0000_00FF, 16'h0000};
        tbl[3] = '{40'hFF_FFFF_FFFF, 16'hFFFF};
        tbl[4] = '{40'h00_007F_FF00, 16'h7FFF};
        tbl[5] = '{40'h00_0080_0000, 16'h7FFF};
        tbl[6] = '{40'hFF_FF80_0000, 16'h8000};
        tbl[7] = '{40'hFF_FFFF_FEFF, 16'hFFFE};

        rst = 1'b1; start = 1'b0; base_addr = '0; num_lines = '0;
        res_valid = 1'b0; res_in = '0; flush = 1'b0;
        tick;
        do_reset;

        // basic two-line layer with exact write timing
        start_layer(8'h10, 2);
        chk("t1 busy", {63'd0, busy}, 64'd1);
        chk("t1 wr_count", {55'd0, wr_count}, 64'd0);
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 40'(i * 256), 1'b0);
            if (i == 3) chk("t1 we early", {63'd0, bram_we}, 64'd0);
            if (i == 4) begin
                chk("t1 we1", {63'd0, bram_we}, 64'd1);
                chk("t1 addr1", {56'd0, bram_addr}, 64'h10);
                chk("t1 din1", bram_din, 64'h0004_0003_0002_0001);
                chk("t1 done1", {63'd0, done}, 64'd0);
            end
            if (i == 8) begin
                chk("t1 addr2", {56'd0, bram_addr}, 64'h11);
                chk("t1 din2", bram_din, 64'h0008_0007_0006_0005);
                chk("t1 done2", {63'd0, done}, 64'd1);
                chk("t1 ready", {63'd0, res_ready}, 64'd0);
                chk("t1 busy end", {63'd0, busy}, 64'd0);
            end
        end
        compare_writes("t1");
        chk("t1 done low", {63'd0, done}, 64'd0);

        // saturation vector table
        start_layer(8'h20, 2);
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, tbl[i].res, 1'b0);
            if (i % 4 == 3) begin
                for (int k = 0; k < 4; k++)
                    chk($sformatf("sat vec%0d", i - 3 + k), {48'd0, bram_din[16*k +: 16]},
                        {48'd0, tbl[i-3+k].exp});
            end
        end
        compare_writes("t2");

        // address wrap
        start_layer(255, 2);
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, rnd(), 1'b0);
            if (i == 3) chk("wrap addr255", {56'd0, bram_addr}, 64'd255);
            if (i == 7) chk("wrap addr0", {56'd0, bram_addr}, 64'd0);
        end
        compare_writes("t3");

        // flush: partial line, then an empty flush
        start_layer(8'h40, 3);
        for (int i = 0; i < 4; i++) drive(1'b1, rnd(), 1'b0);
        drive(1'b1, 40'h00_0000_1200, 1'b0);
        drive(1'b1, 40'hFF_FFFF_F000, 1'b1);
        chk("flush we", {63'd0, bram_we}, 64'd1);
        chk("flush din", bram_din, 64'h0000_0000_FFF0_0012);
        drive(1'b0, '0, 1'b1);
        chk("empty flush we", {63'd0, bram_we}, 64'd0);
        chk("flush busy", {63'd0, busy}, 64'd1);
        compare_writes("t4");
        for (int i = 0; i < 4; i++) drive(1'b1, rnd(), 1'b0);
        compare_writes("t4b");

        // idle: valid ignored, zero-line start, start ignored while active
        for (int i = 0; i < 3; i++) drive(1'b1, rnd(), 1'b0);
        compare_writes("t5 idle");
        start = 1'b1; base_addr = 8'h33; num_lines = 9'd0;
        tick;
        start = 1'b0;
        chk("zero start done", {63'd0, done}, 64'd1);
        chk("zero start we", {63'd0, bram_we}, 64'd0);
        chk("zero start busy", {63'd0, busy}, 64'd0);
        tick;
        chk("zero start done low", {63'd0, done}, 64'd0);
        start_layer(8'h50, 2);
        for (int i = 0; i < 2; i++) drive(1'b1, rnd(), 1'b0);
        start_layer(8'h90, 5);
        for (int i = 0; i < 6; i++) drive(1'b1, rnd(), 1'b0);
        compare_writes("t5 restart");

        // reset mid-layer, then a fresh layer
        start_layer(8'h60, 2);
        for (int i = 0; i < 2; i++) drive(1'b1, rnd(), 1'b0);
        do_reset;
        start_layer(8'h70, 1);
        for (int i = 0; i < 4; i++) drive(1'b1, rnd(), 1'b0);
        compare_writes("t6");

        // randomized layers against the model
        for (int l = 0; l < 30; l++) begin
            int cyc;
            start_layer($urandom_range(0, 255), $urandom_range(1, 4));
            cyc = 0;
            while (m_active && cyc < 200) begin
                drive($urandom_range(0, 3) != 0, rnd(), $urandom_range(0, 7) == 0);
                cyc++;
            end
            if (m_active) chk("rand layer timeout", 64'd1, 64'd0);
            drive(1'b1, rnd(), 1'b0);
            compare_writes("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
